seq_factorial: RTL
==================

SEQ_FACTORIAL -- requirements
Module: seq_factorial

Interface
REQ-001: Parameter IN_W, default 6, is the operand width; n ranges 0..2^IN_W-1.
REQ-002: Parameter OUT_W, default 64, is the result width.
REQ-003: clk  input  1  single clock; all state updates on its rising edge.
REQ-004: rst_n  input  1  asynchronous, active-low reset.
REQ-005: in_valid  input  1  operand n is offered.
REQ-006: in_ready  output  1  block accepts an operand.
REQ-007: in_n  input  IN_W  operand n, unsigned.
REQ-008: out_valid  output  1  result is presented.
REQ-009: out_ready  input  1  consumer takes the result.
REQ-010: out_fact  output  OUT_W  n!, unsigned.
REQ-011: out_ovf  output  1  n! exceeded OUT_W bits.

Function
REQ-012: States SHALL be IDLE, CALC and DONE.
REQ-013: in_ready SHALL be 1 only in IDLE; an accept is in_valid & in_ready at a rising edge.
REQ-014: On accept, the block SHALL load acc=1, cnt=in_n and ovf=0, and SHALL enter CALC.
REQ-015: In CALC, when cnt<=1 the block SHALL enter DONE at the next edge; otherwise it SHALL update acc=acc*cnt, decrement cnt and set ovf if the full product has any bit set above OUT_W-1.
REQ-016: out_valid SHALL rise exactly max(n,1) clocks after the accept edge (n=5 -> 5, n=0 -> 1, n=1 -> 1).
REQ-017: ovf SHALL be sticky; after it is set, acc SHALL keep multiplying the truncated value, or saturating per REQ-024.
REQ-018: In DONE, out_valid SHALL be 1, and out_fact and out_ovf SHALL hold stable until out_ready=1.
REQ-019: DONE with out_ready=1 SHALL return to IDLE; the next accept SHALL be possible no earlier than the following edge.
REQ-020: in_valid SHALL be ignored outside IDLE, and in_n SHALL be sampled only at accept.
REQ-021: out_fact and out_ovf SHALL be 0 whenever out_valid=0.

Reset
REQ-022: On rst_n=0, the block SHALL enter IDLE immediately with acc=0, cnt=0, ovf=0, out_valid=0 and in_ready=0 for as long as rst_n is low.
REQ-023: If reset is asserted in CALC or DONE, the block SHALL abandon the computation and produce no result after release; in_ready SHALL be 1 on the first edge after release.

Configuration
REQ-024: With macro FACT_SAT_EN defined, once ovf=1 acc SHALL be forced to all-ones and out_fact SHALL be 2^OUT_W-1; without it, out_fact SHALL be n! mod 2^OUT_W. out_ovf SHALL be reported in both builds.

Structure
REQ-025: Package fact_pkg SHALL hold the state enum (IDLE/CALC/DONE) and the default width constants FACT_IN_W=6 and FACT_OUT_W=64.
REQ-026: Sub-module fact_mul SHALL be a combinational OUT_W x IN_W multiplier returning the low OUT_W product bits and an overflow bit; seq_factorial SHALL hold all state.

Verification
REQ-027: Accept in_n=5 with out_ready=1 -> out_valid 5 clocks later, out_fact=120, out_ovf=0.
REQ-028: in_n=0, then in_n=1 -> each gives out_fact=1 after 1 clock, out_ovf=0.
REQ-029: in_n=20 -> out_fact=2432902008176640000, out_ovf=0; in_n=21 -> out_ovf=1, and out_fact=0xFFFFFFFFFFFFFFFF with FACT_SAT_EN or 21! mod 2^64 (=0xC5077D36B8C40000) without it.
REQ-030: in_n=4 with out_ready=0 for 10 clocks -> out_fact=24 held stable, in_ready=0, and a pulse of in_valid with in_n=7 is ignored; then out_ready=1 -> IDLE next edge.
REQ-031: in_n=10 accepted, rst_n pulsed low 3 clocks into CALC -> out_valid never rises; a fresh in_n=3 -> out_fact=6 after 3 clocks.
REQ-032: Back-to-back operands 2, 13, 9, 8 with out_ready=1 -> results 2, 6227020800, 362880, 40320 in order, none lost.

Source files
------------

// File: rtl/fact_pkg.sv
// Shared types and default widths for the sequential factorial block.
package fact_pkg;

    localparam int unsigned FACT_IN_W  = 6;
    localparam int unsigned FACT_OUT_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } fact_state_e;

endpackage

// File: rtl/fact_mul.sv
// Combinational OUT_W x IN_W multiplier: low OUT_W product bits plus an
// overflow flag raised when any higher product bit is set.
module fact_mul
    import fact_pkg::*;
#(
    parameter int unsigned OUT_W = FACT_OUT_W,
    parameter int unsigned IN_W  = FACT_IN_W
) (
    input  logic [OUT_W-1:0] a_i,
    input  logic [IN_W-1:0]  b_i,
    output logic [OUT_W-1:0] p_o,
    output logic             ovf_o
);

    logic [OUT_W+IN_W-1:0] a_ext;
    logic [OUT_W+IN_W-1:0] b_ext;
    logic [OUT_W+IN_W-1:0] full;

    always_comb begin
        a_ext = {{IN_W{1'b0}}, a_i};
        b_ext = {{OUT_W{1'b0}}, b_i};
        full  = a_ext * b_ext;
        p_o   = full[OUT_W-1:0];
        ovf_o = |full[OUT_W+IN_W-1:OUT_W];
    end

endmodule

// File: rtl/seq_factorial.sv
// Sequential n! with valid/ready handshakes on operand and result.
// Define FACT_SAT_EN to saturate the result to all-ones once it overflows.
module seq_factorial
    import fact_pkg::*;
#(
    parameter int unsigned IN_W  = FACT_IN_W,
    parameter int unsigned OUT_W = FACT_OUT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_n,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_fact,
    output logic             out_ovf
);

    fact_state_e      state_q;
    logic [OUT_W-1:0] acc_q;
    logic [OUT_W-1:0] acc_d;
    logic [IN_W-1:0]  cnt_q;
    logic             ovf_q;
    logic             ovf_d;
    logic             out_valid_q;
    logic             in_ready_q;

    logic [OUT_W-1:0] mul_p;
    logic             mul_ovf;

    fact_mul #(
        .OUT_W (OUT_W),
        .IN_W  (IN_W)
    ) u_mul (
        .a_i   (acc_q),
        .b_i   (cnt_q),
        .p_o   (mul_p),
        .ovf_o (mul_ovf)
    );

    always_comb begin
        ovf_d = ovf_q | mul_ovf;
`ifdef FACT_SAT_EN
        acc_d = ovf_d ? '1 : mul_p;
`else
        acc_d = mul_p;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        acc_q      <= OUT_W'(1);
                        cnt_q      <= in_n;
                        ovf_q      <= 1'b0;
                        in_ready_q <= 1'b0;
                        state_q    <= CALC;
                    end
                end
                CALC: begin
                    // Terminating on cnt<=1 gives a latency of max(n,1) edges.
                    if (cnt_q <= IN_W'(1)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q - IN_W'(1);
                        ovf_q <= ovf_d;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_fact  = out_valid_q ? acc_q : '0;
    assign out_ovf   = out_valid_q & ovf_q;

endmodule
